// File: rtl/sdrc_responder.sv
// sdrc_responder: BRAM-backed stand-in for the SDRC controller user interface.
// Fixed-latency read/write bursts; protocol misuse raises a sticky protocol_error.
module sdrc_responder #(
  parameter int DepthBitWidth = 12,
  parameter int InitCycles    = 16,
  parameter int ReadLatency   = 3,
  parameter int RefreshCycles = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_sdrc_cmd_en,
  input  logic [2:0]  I_sdrc_cmd,
  input  logic [20:0] I_sdrc_addr,
  input  logic [7:0]  I_sdrc_data_len,
  input  logic [31:0] I_sdrc_data,
  input  logic [3:0]  I_sdrc_dqm,
  input  logic        I_sdrc_precharge_ctrl,
  input  logic        I_sdram_power_down,
  input  logic        I_sdram_selfrefresh,
  output logic [31:0] O_sdrc_data,
  output logic        O_sdrc_init_done,
  output logic        O_sdrc_cmd_ack,
  output logic        rd_valid,
  output logic        protocol_error
);

  localparam int Depth = 1 << DepthBitWidth;
  localparam int InitW = $clog2(InitCycles + 1);
  localparam logic [InitW-1:0] InitLast = InitW'(InitCycles - 1);
  localparam logic [InitW-1:0] InitOne = InitW'(1);
  localparam logic [7:0] WaitLoad = 8'(ReadLatency - 2);
  localparam logic [8:0] RefreshLoad = 9'(RefreshCycles);
  localparam logic [DepthBitWidth-1:0] AddrOne = DepthBitWidth'(1);

  localparam logic [2:0] CmdActivate  = 3'b011;
  localparam logic [2:0] CmdPrecharge = 3'b010;
  localparam logic [2:0] CmdWrite     = 3'b100;
  localparam logic [2:0] CmdRead      = 3'b101;
  localparam logic [2:0] CmdRefresh   = 3'b001;
  localparam logic [2:0] CmdNop       = 3'b111;

  typedef enum logic [2:0] {StInit, StIdle, StWrite, StRead, StRefresh} state_t;

  state_t                    state_r, state_s;
  logic [8:0]                rem_r, rem_s;
  logic [7:0]                wait_r, wait_s;
  logic [DepthBitWidth-1:0]  addr_r, addr_s, waddr_s, base_s;
  logic [InitW-1:0]          init_cnt_r, init_cnt_s;
  logic                      init_done_r, init_done_s;
  logic                      row_open_r, row_open_s;
  logic                      ack_r, ack_s;
  logic                      err_r, err_s;
  logic                      rd_valid_r, rd_valid_s;
  logic [31:0]               rd_data_r, rd_data_s;
  logic                      we_s;
  logic                      ctrl_bad_s;
  logic                      unused_s;
  logic [31:0]               mem_r [Depth];

  assign base_s     = I_sdrc_addr[DepthBitWidth-1:0];
  assign unused_s   = ^I_sdrc_addr[20:DepthBitWidth];
  assign ctrl_bad_s = I_sdrc_precharge_ctrl | I_sdram_power_down | I_sdram_selfrefresh;

  // Next-state and next-output logic for the command/burst sequencer.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    wait_s      = wait_r;
    addr_s      = addr_r;
    init_cnt_s  = init_cnt_r;
    init_done_s = init_done_r;
    row_open_s  = row_open_r;
    ack_s       = 1'b0;
    err_s       = err_r;
    rd_data_s   = rd_data_r;
    rd_valid_s  = rd_valid_r;
    we_s        = 1'b0;
    waddr_s     = addr_r;
    case (state_r)
      StInit: begin
        err_s = err_r | I_sdrc_cmd_en;
        if (init_cnt_r == InitLast) begin
          init_done_s = 1'b1;
          state_s     = StIdle;
        end else begin
          init_cnt_s = init_cnt_r + InitOne;
        end
      end
      StIdle: begin
        rd_data_s  = 32'd0;
        rd_valid_s = 1'b0;
        err_s      = err_r | ctrl_bad_s;
        if (I_sdrc_cmd_en) begin
          case (I_sdrc_cmd)
            CmdActivate: begin
              ack_s      = 1'b1;
              row_open_s = 1'b1;
            end
            CmdPrecharge: begin
              ack_s      = 1'b1;
              row_open_s = 1'b0;
            end
            CmdWrite: begin
              // Word 0 is written on the command edge itself.
              ack_s   = 1'b1;
              we_s    = 1'b1;
              waddr_s = base_s;
              addr_s  = base_s + AddrOne;
              rem_s   = {1'b0, I_sdrc_data_len};
              err_s   = err_s | ~row_open_r;
              if (I_sdrc_data_len != 8'd0) begin
                state_s = StWrite;
              end else begin
                state_s = StIdle;
              end
            end
            CmdRead: begin
              ack_s   = 1'b1;
              addr_s  = base_s;
              rem_s   = {1'b0, I_sdrc_data_len} + 9'd1;
              wait_s  = WaitLoad;
              err_s   = err_s | ~row_open_r;
              state_s = StRead;
            end
            CmdRefresh: begin
              ack_s   = 1'b1;
              rem_s   = RefreshLoad;
              err_s   = err_s | row_open_r;
              state_s = StRefresh;
            end
            CmdNop: begin
              state_s = StIdle;
            end
            default: begin
              err_s = 1'b1;
            end
          endcase
        end else begin
          state_s = StIdle;
        end
      end
      StWrite: begin
        err_s  = err_r | I_sdrc_cmd_en;
        we_s   = 1'b1;
        addr_s = addr_r + AddrOne;
        rem_s  = rem_r - 9'd1;
        if (rem_r == 9'd1) begin
          state_s = StIdle;
        end else begin
          state_s = StWrite;
        end
      end
      StRead: begin
        err_s = err_r | I_sdrc_cmd_en;
        if (wait_r != 8'd0) begin
          wait_s = wait_r - 8'd1;
        end else begin
          // Leaving on the last word lets the next command land one edge later.
          rd_data_s  = mem_r[addr_r];
          rd_valid_s = 1'b1;
          addr_s     = addr_r + AddrOne;
          rem_s      = rem_r - 9'd1;
          if (rem_r == 9'd1) begin
            state_s = StIdle;
          end else begin
            state_s = StRead;
          end
        end
      end
      StRefresh: begin
        err_s = err_r | I_sdrc_cmd_en;
        rem_s = rem_r - 9'd1;
        if (rem_r == 9'd1) begin
          state_s = StIdle;
        end else begin
          state_s = StRefresh;
        end
      end
      default: begin
        state_s = StInit;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= StInit;
      rem_r       <= 9'd0;
      wait_r      <= 8'd0;
      addr_r      <= '0;
      init_cnt_r  <= '0;
      init_done_r <= 1'b0;
      row_open_r  <= 1'b0;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      rd_data_r   <= 32'd0;
      rd_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      rem_r       <= rem_s;
      wait_r      <= wait_s;
      addr_r      <= addr_s;
      init_cnt_r  <= init_cnt_s;
      init_done_r <= init_done_s;
      row_open_r  <= row_open_s;
      ack_r       <= ack_s;
      err_r       <= err_s;
      rd_data_r   <= rd_data_s;
      rd_valid_r  <= rd_valid_s;
    end
  end

  // Byte-masked memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (!I_sdrc_dqm[b]) begin
          mem_r[waddr_s][b*8 +: 8] <= I_sdrc_data[b*8 +: 8];
        end
      end
    end
  end

  assign O_sdrc_data      = rd_data_r;
  assign O_sdrc_init_done = init_done_r;
  assign O_sdrc_cmd_ack   = ack_r;
  assign rd_valid         = rd_valid_r;
  assign protocol_error   = err_r;

endmodule

// File: tb/tb_sdrc_responder.sv
// tb_sdrc_responder: table-driven and randomized self-checking bench for sdrc_responder.
// A word-level memory model predicts every burst word and the sticky error flag.
module tb_sdrc_responder;
  localparam int RL    = 3;
  localparam int RC    = 8;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I_sdrc_cmd_en;
  logic [2:0]  I_sdrc_cmd;
  logic [20:0] I_sdrc_addr;
  logic [7:0]  I_sdrc_data_len;
  logic [31:0] I_sdrc_data;
  logic [3:0]  I_sdrc_dqm;
  logic        I_sdrc_precharge_ctrl;
  logic        I_sdram_power_down;
  logic        I_sdram_selfrefresh;
  logic [31:0] O_sdrc_data;
  logic        O_sdrc_init_done;
  logic        O_sdrc_cmd_ack;
  logic        rd_valid;
  logic        protocol_error;

  always #5 clk = ~clk;

  sdrc_responder dut (
    .clk(clk), .rst_n(rst_n),
    .I_sdrc_cmd_en(I_sdrc_cmd_en), .I_sdrc_cmd(I_sdrc_cmd), .I_sdrc_addr(I_sdrc_addr),
    .I_sdrc_data_len(I_sdrc_data_len), .I_sdrc_data(I_sdrc_data), .I_sdrc_dqm(I_sdrc_dqm),
    .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl), .I_sdram_power_down(I_sdram_power_down),
    .I_sdram_selfrefresh(I_sdram_selfrefresh), .O_sdrc_data(O_sdrc_data),
    .O_sdrc_init_done(O_sdrc_init_done), .O_sdrc_cmd_ack(O_sdrc_cmd_ack),
    .rd_valid(rd_valid), .protocol_error(protocol_error)
  );

  typedef struct {
    logic       en;
    logic [2:0] cmd;
    logic [2:0] ctrl;
    logic       exp_ack;
    logic       exp_err;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl [int];
  bit          row_open_m;
  bit          err_m;
  logic [31:0] wdata [256];
  logic [3:0]  wdqm [256];
  vec_t        vecs [7];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    I_sdrc_cmd_en         = 1'b0;
    I_sdrc_cmd            = 3'b111;
    I_sdrc_precharge_ctrl = 1'b0;
    I_sdram_power_down    = 1'b0;
    I_sdram_selfrefresh   = 1'b0;
  endtask

  task automatic do_reset(input bit poke);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    check32("rst_data", O_sdrc_data, 32'd0);
    check1("rst_init_done", O_sdrc_init_done, 1'b0);
    check1("rst_ack", O_sdrc_cmd_ack, 1'b0);
    check1("rst_rd_valid", rd_valid, 1'b0);
    check1("rst_err", protocol_error, 1'b0);
    rst_n = 1'b1;
    if (poke) begin
      I_sdrc_cmd_en = 1'b1;
      I_sdrc_cmd    = 3'b011;
    end
    tick();
    check1("init_early_ack", O_sdrc_cmd_ack, 1'b0);
    check1("init_early_err", protocol_error, poke);
    idle_inputs();
    repeat (14) tick();
    check1("init_done_early", O_sdrc_init_done, 1'b0);
    tick();
    check1("init_done_rise", O_sdrc_init_done, 1'b1);
    row_open_m = 1'b0;
    err_m      = poke;
  endtask

  task automatic simple_cmd(input logic [2:0] c);
    logic exp_ack;
    exp_ack = (c == 3'b011) || (c == 3'b010);
    if (c == 3'b011) row_open_m = 1'b1;
    if (c == 3'b010) row_open_m = 1'b0;
    if (c == 3'b000 || c == 3'b110) err_m = 1'b1;
    I_sdrc_cmd_en = 1'b1;
    I_sdrc_cmd    = c;
    tick();
    check1("cmd_ack", O_sdrc_cmd_ack, exp_ack);
    idle_inputs();
    tick();
    check1("cmd_ack_pulse", O_sdrc_cmd_ack, 1'b0);
    check1("cmd_err", protocol_error, err_m);
  endtask

  task automatic write_burst(input logic [20:0] a, input int len);
    logic [31:0] w;
    int idx;
    if (!row_open_m) err_m = 1'b1;
    for (int k = 0; k <= len; k++) begin
      idx = (int'(a[11:0]) + k) % DEPTH;
      w = mdl.exists(idx) ? mdl[idx] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (!wdqm[k][b]) w[b*8 +: 8] = wdata[k][b*8 +: 8];
      end
      mdl[idx] = w;
    end
    I_sdrc_cmd_en   = 1'b1;
    I_sdrc_cmd      = 3'b100;
    I_sdrc_addr     = a;
    I_sdrc_data_len = 8'(len);
    I_sdrc_data     = wdata[0];
    I_sdrc_dqm      = wdqm[0];
    tick();
    check1("wr_ack", O_sdrc_cmd_ack, 1'b1);
    idle_inputs();
    for (int k = 1; k <= len; k++) begin
      I_sdrc_data = wdata[k];
      I_sdrc_dqm  = wdqm[k];
      tick();
      if (k == 1) check1("wr_ack_pulse", O_sdrc_cmd_ack, 1'b0);
    end
    I_sdrc_data = 32'd0;
    I_sdrc_dqm  = 4'd0;
    check1("wr_err", protocol_error, err_m);
  endtask

  task automatic read_burst(input logic [20:0] a, input int len, input int poke_at, input bit chain);
    logic [31:0] exp_w [256];
    int idx;
    for (int k = 0; k <= len; k++) begin
      idx = (int'(a[11:0]) + k) % DEPTH;
      exp_w[k] = mdl.exists(idx) ? mdl[idx] : 32'h0;
    end
    if (!row_open_m) err_m = 1'b1;
    if (poke_at > 0) err_m = 1'b1;
    I_sdrc_cmd_en   = 1'b1;
    I_sdrc_cmd      = 3'b101;
    I_sdrc_addr     = a;
    I_sdrc_data_len = 8'(len);
    tick();
    check1("rd_ack", O_sdrc_cmd_ack, 1'b1);
    for (int e = 1; e <= RL + len; e++) begin
      idle_inputs();
      if (e == poke_at || (chain && e == RL + len)) begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = 3'b011;
      end
      tick();
      if (e >= RL - 1 && e <= RL - 1 + len) begin
        check1("rd_valid", rd_valid, 1'b1);
        check32("rd_data", O_sdrc_data, exp_w[e-RL+1]);
      end else begin
        check1("rd_valid_idle", rd_valid, 1'b0);
        check32("rd_data_idle", O_sdrc_data, 32'd0);
      end
      if (chain && e == RL + len) check1("rd_chain_ack", O_sdrc_cmd_ack, 1'b1);
      else check1("rd_ack_low", O_sdrc_cmd_ack, 1'b0);
    end
    if (chain) row_open_m = 1'b1;
    idle_inputs();
    check1("rd_err", protocol_error, err_m);
  endtask

  task automatic refresh_cmd();
    if (row_open_m) err_m = 1'b1;
    I_sdrc_cmd_en = 1'b1;
    I_sdrc_cmd    = 3'b001;
    tick();
    check1("ref_ack", O_sdrc_cmd_ack, 1'b1);
    idle_inputs();
    repeat (RC) tick();
    check1("ref_err", protocol_error, err_m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    I_sdrc_addr = 21'd0;
    I_sdrc_data_len = 8'd0;
    I_sdrc_data = 32'd0;
    I_sdrc_dqm = 4'd0;
    tick();

    do_reset(1'b1);
    do_reset(1'b0);

    // Single-edge commands in Idle; expected error is cumulative.
    vecs[0] = '{en: 1'b1, cmd: 3'b011, ctrl: 3'b000, exp_ack: 1'b1, exp_err: 1'b0};
    vecs[1] = '{en: 1'b1, cmd: 3'b111, ctrl: 3'b000, exp_ack: 1'b0, exp_err: 1'b0};
    vecs[2] = '{en: 1'b1, cmd: 3'b010, ctrl: 3'b000, exp_ack: 1'b1, exp_err: 1'b0};
    vecs[3] = '{en: 1'b0, cmd: 3'b011, ctrl: 3'b000, exp_ack: 1'b0, exp_err: 1'b0};
    vecs[4] = '{en: 1'b0, cmd: 3'b111, ctrl: 3'b010, exp_ack: 1'b0, exp_err: 1'b1};
    vecs[5] = '{en: 1'b1, cmd: 3'b000, ctrl: 3'b000, exp_ack: 1'b0, exp_err: 1'b1};
    vecs[6] = '{en: 1'b1, cmd: 3'b110, ctrl: 3'b000, exp_ack: 1'b0, exp_err: 1'b1};
    for (int i = 0; i < 7; i++) begin
      I_sdrc_cmd_en = vecs[i].en;
      I_sdrc_cmd    = vecs[i].cmd;
      {I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh} = vecs[i].ctrl;
      tick();
      check1("tbl_ack", O_sdrc_cmd_ack, vecs[i].exp_ack);
      idle_inputs();
      tick();
      check1("tbl_ack_pulse", O_sdrc_cmd_ack, 1'b0);
      check1("tbl_err", protocol_error, vecs[i].exp_err);
    end

    do_reset(1'b0);
    simple_cmd(3'b011);
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 32'h11 * (k + 1);
      wdqm[k]  = 4'b0000;
    end
    write_burst(21'h40, 7);
    read_burst(21'h40, 7, 0, 1'b0);

    wdata[0] = 32'hAABBCCDD; wdqm[0] = 4'b0000;
    write_burst(21'h05, 0);
    wdata[0] = 32'h11223344; wdqm[0] = 4'b0101;
    write_burst(21'h05, 0);
    read_burst(21'h05, 0, 0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      wdata[k] = $urandom;
      wdqm[k]  = 4'b0000;
    end
    write_burst(21'(DEPTH - 2), 3);
    read_burst(21'(DEPTH - 2), 3, 0, 1'b0);
    read_burst(21'h1FF000, 1, 0, 1'b0);

    simple_cmd(3'b010);
    read_burst(21'h40, 2, 0, 1'b0);

    do_reset(1'b0);
    simple_cmd(3'b011);
    read_burst(21'h40, 5, 4, 1'b0);

    // Reset asserted in the middle of a read burst.
    do_reset(1'b0);
    simple_cmd(3'b011);
    I_sdrc_cmd_en   = 1'b1;
    I_sdrc_cmd      = 3'b101;
    I_sdrc_addr     = 21'h40;
    I_sdrc_data_len = 8'd7;
    tick();
    idle_inputs();
    repeat (RL) tick();
    check1("mid_burst_valid", rd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_rst_valid", rd_valid, 1'b0);
    check32("async_rst_data", O_sdrc_data, 32'd0);
    do_reset(1'b0);
    simple_cmd(3'b011);
    read_burst(21'h40, 7, 0, 1'b0);

    // Refresh: busy right after the command, accepts again afterwards.
    simple_cmd(3'b010);
    I_sdrc_cmd_en = 1'b1;
    I_sdrc_cmd    = 3'b001;
    tick();
    check1("ref_busy_ack", O_sdrc_cmd_ack, 1'b1);
    I_sdrc_cmd = 3'b011;
    tick();
    check1("ref_busy_ignored", O_sdrc_cmd_ack, 1'b0);
    idle_inputs();
    repeat (RC) tick();
    check1("ref_busy_err", protocol_error, 1'b1);
    err_m = 1'b1;
    simple_cmd(3'b011);
    do_reset(1'b0);
    simple_cmd(3'b011);
    refresh_cmd();

    // Randomized traffic against the model.
    do_reset(1'b0);
    simple_cmd(3'b011);
    for (int k = 0; k < 128; k++) begin
      wdata[k] = $urandom;
      wdqm[k]  = 4'b0000;
    end
    write_burst(21'h0, 127);
    for (int t = 0; t < 40; t++) begin
      int op, base, len;
      logic [20:0] a;
      op   = $urandom_range(0, 5);
      base = $urandom_range(0, 100);
      len  = $urandom_range(0, 15);
      a    = {9'($urandom), 12'(base)};
      case (op)
        0: simple_cmd(3'b011);
        1: simple_cmd(3'b010);
        2: simple_cmd(3'b111);
        3: begin
          for (int k = 0; k <= len; k++) begin
            wdata[k] = $urandom;
            wdqm[k]  = 4'($urandom);
          end
          write_burst(a, len);
        end
        4: read_burst(a, len, 0, 1'($urandom_range(0, 1)));
        default: refresh_cmd();
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
